// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal BHT plus direct-mapped BTB fetch predictor
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      f_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int N = 1 << IDX_W;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  logic [1:0]       bht        [N];
  logic             btb_valid  [N];
  logic [TAG_W-1:0] btb_tag    [N];
  logic [31:0]      btb_target [N];

  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             f_hit;
  logic             u_hit;

  assign f_idx = f_pc[IDX_W+1:2];
  assign f_tag = f_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Bits outside index/tag play no part in lookup; gathered here to mark them intentionally unused.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[31:IDX_W+TAG_W+2], f_pc[1:0], upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0]};

  // Zero-latency lookup for fetch; reads the state as it stood before this cycle's update.
  always_comb begin
    f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    pred_taken  = f_hit && bht[f_idx][1];
    pred_target = pred_taken ? btb_target[f_idx] : f_pc + 32'd4;
  end

  // Resolve direction and target against what was predicted for this branch.
  always_comb begin
    u_hit       = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
    mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = (upd_valid && upd_taken) ? upd_target : upd_pc + 32'd4;
  end

  // Train BHT counters and allocate/retag BTB entries on taken branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        bht[i]        <= WNT;
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        btb_valid[u_idx]  <= 1'b1;
        btb_tag[u_idx]    <= u_tag;
        btb_target[u_idx] <= upd_target;
        // A freshly (re)allocated entry starts weakly taken rather than inheriting the old owner's history.
        if (!u_hit)
          bht[u_idx] <= WT;
        else if (bht[u_idx] != ST)
          bht[u_idx] <= bht[u_idx] + 2'd1;
      end else if (bht[u_idx] != SNT) begin
        bht[u_idx] <= bht[u_idx] - 2'd1;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (upd_valid && (br_cnt != '1))
        br_cnt <= br_cnt + 1'b1;
      if (mispredict && (mp_cnt != '1))
        mp_cnt <= mp_cnt + 1'b1;
    end
  end

  assign br_count = br_cnt;
  assign mp_count = mp_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed scoreboard bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  branch_predictor #(.IDX_W(6), .TAG_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "pred_taken":  return {31'b0, pred_taken};
      "pred_target": return pred_target;
      "mispredict":  return {31'b0, mispredict};
      "redirect_pc": return redirect_pc;
      "br_count":    return br_count;
      "mp_count":    return mp_count;
      default:       return 'x;
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic exp_pred(input logic t, input logic [31:0] tgt);
    push("pred_taken", {31'b0, t});
    push("pred_target", tgt);
  endtask

  task automatic exp_mp(input logic m, input logic [31:0] r);
    push("mispredict", {31'b0, m});
    push("redirect_pc", r);
  endtask

  task automatic exp_cnt(input logic [31:0] b, input logic [31:0] m);
    push("br_count", b);
    push("mp_count", m);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.tag);
      checks++;
      assert (obs === e.val) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    upd_valid       = v;
    upd_pc          = pc;
    upd_taken       = t;
    upd_target      = tgt;
    upd_pred_taken  = pt;
    upd_pred_target = ptgt;
  endtask

  task automatic idle();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    f_pc  = 32'h100;
    set_upd(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    exp_pred(1'b0, 32'h104);
    exp_mp(1'b0, 32'h104);
    exp_cnt(32'd0, 32'd0);
    drain();

    @(negedge clk);
    rst_n = 1'b1;

    // First taken branch: direction mispredict, fetch still sees the old state.
    @(negedge clk);
    set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    exp_mp(1'b1, 32'h80);
    exp_pred(1'b0, 32'h104);
    #1 drain();

    @(negedge clk);
    idle();
    exp_pred(1'b1, 32'h80);
    exp_cnt(32'd1, 32'd1);
    #1 drain();

    // Two correctly predicted taken updates drive the counter to ST.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      exp_mp(1'b0, 32'h80);
      #1 drain();
    end
    @(negedge clk);
    idle();
    exp_pred(1'b1, 32'h80);
    exp_cnt(32'd3, 32'd1);
    #1 drain();

    // Not-taken #1: ST -> WT, still predicted taken.
    @(negedge clk);
    set_upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    exp_mp(1'b1, 32'h104);
    #1 drain();
    @(negedge clk);
    idle();
    exp_pred(1'b1, 32'h80);
    exp_cnt(32'd4, 32'd2);
    #1 drain();

    // Not-taken #2: WT -> WNT, now predicted not taken.
    @(negedge clk);
    set_upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    exp_mp(1'b1, 32'h104);
    #1 drain();
    @(negedge clk);
    idle();
    exp_pred(1'b0, 32'h104);
    exp_cnt(32'd5, 32'd3);
    #1 drain();

    // Alias: retrain 0x100, then a taken branch at 0x200 retags index 0 to WT.
    @(negedge clk);
    set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    exp_mp(1'b1, 32'h80);
    #1 drain();
    @(negedge clk);
    set_upd(1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h204);
    f_pc = 32'h100;
    exp_mp(1'b1, 32'h200);
    exp_pred(1'b1, 32'h80);
    #1 drain();
    @(negedge clk);
    idle();
    f_pc = 32'h100;
    exp_pred(1'b0, 32'h104);
    #1 drain();
    f_pc = 32'h200;
    exp_pred(1'b1, 32'h200);
    exp_cnt(32'd7, 32'd5);
    #1 drain();

    // One not-taken from WT must drop to WNT (would stay taken had it been ST).
    @(negedge clk);
    set_upd(1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
    exp_mp(1'b1, 32'h204);
    #1 drain();
    @(negedge clk);
    idle();
    exp_pred(1'b0, 32'h204);
    exp_cnt(32'd8, 32'd6);
    #1 drain();

    @(negedge clk);
    set_upd(1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h204);
    exp_mp(1'b1, 32'h200);
    #1 drain();
    @(negedge clk);
    idle();
    exp_pred(1'b1, 32'h200);
    exp_cnt(32'd9, 32'd7);
    #1 drain();

    // Target-only mispredict at 0x104, with same-cycle collision checks.
    @(negedge clk);
    set_upd(1'b1, 32'h104, 1'b1, 32'h80, 1'b0, 32'h108);
    f_pc = 32'h104;
    exp_mp(1'b1, 32'h80);
    exp_pred(1'b0, 32'h108);
    #1 drain();
    @(negedge clk);
    set_upd(1'b1, 32'h104, 1'b1, 32'h80, 1'b1, 32'h84);
    exp_mp(1'b1, 32'h80);
    exp_pred(1'b1, 32'h80);
    #1 drain();
    @(negedge clk);
    set_upd(1'b1, 32'h104, 1'b1, 32'h80, 1'b1, 32'h80);
    exp_mp(1'b0, 32'h80);
    #1 drain();
    @(negedge clk);
    idle();
    exp_cnt(32'd12, 32'd9);
    #1 drain();

    // Branch counter saturation.
    @(negedge clk);
    force dut.br_cnt = 32'hFFFF_FFFF;
    #1 release dut.br_cnt;
    exp_cnt(32'hFFFF_FFFF, 32'd9);
    #1 drain();
    @(negedge clk);
    set_upd(1'b1, 32'h108, 1'b0, 32'h0, 1'b0, 32'h10c);
    exp_mp(1'b0, 32'h10c);
    #1 drain();
    @(negedge clk);
    idle();
    exp_cnt(32'hFFFF_FFFF, 32'd9);
    #1 drain();

    // Reset asserted in the middle of a taken update.
    @(negedge clk);
    set_upd(1'b1, 32'h10c, 1'b1, 32'h300, 1'b0, 32'h110);
    f_pc = 32'h10c;
    #2 rst_n = 1'b0;
    exp_pred(1'b0, 32'h110);
    exp_cnt(32'd0, 32'd0);
    exp_mp(1'b1, 32'h300);
    #1 drain();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    f_pc = 32'h10c;
    exp_pred(1'b0, 32'h110);
    #1 drain();
    f_pc = 32'h100;
    exp_pred(1'b0, 32'h104);
    exp_cnt(32'd0, 32'd0);
    #1 drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor for the 3-stage RISC-V pipeline.
- Predicts conditional-branch direction and target for the fetch PC: a bimodal table of 2-bit counters (BHT) plus a direct-mapped branch target buffer (BTB).
- Trained from execute by the resolved br_taken of the branch comparator; flags a mispredict and supplies the redirect PC to fetch.
- Keeps saturating performance counters.

Parameters:
- IDX_W, 6, index bits; BHT and BTB each hold 2**IDX_W entries.
- TAG_W, 8, BTB tag bits taken from PC above the index.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- f_pc  input  32  fetch PC.
- pred_taken  output  1  predicted taken for f_pc (combinational).
- pred_target  output  32  predicted target; equals f_pc+4 when pred_taken=0.
- upd_valid  input  1  execute stage holds a resolved conditional branch this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  resolved outcome (br_taken).
- upd_target  input  32  computed branch target.
- upd_pred_taken  input  1  prediction carried down the pipe with this branch.
- upd_pred_target  input  32  predicted target carried down the pipe.
- mispredict  output  1  flush request (combinational).
- redirect_pc  output  32  correct next PC; valid when mispredict=1.
- br_count  output  CNT_W  resolved branches since reset.
- mp_count  output  CNT_W  mispredicts since reset.

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - pc[1:0] is ignored.
- Prediction (combinational, zero latency):
  - hit = btb_valid[idx] && btb_tag[idx]==tag.
  - pred_taken = hit && bht[idx][1].
  - pred_target = pred_taken ? btb_target[idx] : f_pc+4, 32-bit wrap.
- Mispredict (combinational, from upd_* only):
  - mispredict = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - When upd_valid=0: mispredict=0 and redirect_pc is don't-care (drive upd_pc+4).
- BHT counter, per entry, updated at the clock edge when upd_valid=1:
  - States: SNT=00, WNT=01, WT=10, ST=11.
  - Taken increments, saturating at ST; not-taken decrements, saturating at SNT.
- BTB, written at the clock edge when upd_valid && upd_taken:
  - valid=1, tag=upd tag, target=upd_target.
  - On a tag change, the entry's BHT counter is written to WT in the same cycle instead of the increment.
  - Not-taken updates never modify the BTB.
  - A not-taken update whose tag misses the BTB still decrements the BHT counter.
- Read/write collision: f_pc and upd_pc at the same idx in the same cycle → prediction uses the pre-update state; the new state is visible next cycle. No bypass.
- Performance counters:
  - br_count increments on each upd_valid.
  - mp_count increments on each mispredict.
  - Both saturate at all-ones; no wrap.
- Reset (async assert, sync-to-clk deassert handled upstream):
  - All BHT entries = WNT; all btb_valid = 0; br_count = mp_count = 0.
  - Outputs immediately: pred_taken=0, pred_target=f_pc+4, mispredict follows inputs.
  - Reset asserted mid-update cancels that cycle's write.
- No storage is written when upd_valid=0. The block has no stall input; the pipeline holds upd_valid low during stalls.

Test Plan:
- After reset, f_pc=0x100 → pred_taken=0, pred_target=0x104; br_count=0, mp_count=0.
- upd_valid=1, upd_pc=0x100, upd_taken=1, upd_target=0x80, upd_pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle f_pc=0x100 → pred_taken=1, pred_target=0x80; mp_count=1.
- Two more taken updates at 0x100 (counter saturates at ST), then two not-taken updates → pred_taken stays 1 after the first, becomes 0 after the second; redirect_pc=0x104 on each not-taken mispredict.
- Alias check: train 0x100 taken to 0x80, then a taken update at 0x100+(4<<IDX_W) with target 0x200 → the entry is retagged, counter=WT. f_pc=0x100 → pred_taken=0. f_pc at the alias → pred_target=0x200.
- Taken update with correct direction but upd_pred_target=0x84 vs upd_target=0x80 → mispredict=1, redirect_pc=0x80. Same-cycle f_pc at that index shows the old prediction.
- Preload br_count to all-ones via force, then upd_valid=1 → br_count holds all-ones. Assert rst_n=0 mid-update → all outputs reset, the table is not written.
